// File: rtl/muldiv_sequencer_if.sv
// Bus between the pipeline controller / shared adder and the MUL/DIV/MOD sequencer.
// The slave side is the sequencer; the master side is the pipeline plus the shared adder.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_s;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  modport slave (
    input  start, op, opa, opb, add_sum, add_cout,
    output busy, done, result, add_a, add_b, add_s
  );

  modport master (
    output start, op, opa, opb, add_sum, add_cout,
    input  busy, done, result, add_a, add_b, add_s
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MUL/DIV/MOD sequencer. One shift-add (multiply) or restoring
// (divide) iteration per cycle, using an external shared adder/subtracter that is
// driven only while the unit is in RUN.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  muldiv_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MOD = 2'b10;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] trial_s;
  logic             shout_s;
  logic             op_div_s;
  logic             start_div_s;

  // Reserved opcode 11 is treated as MUL, so only 01/10 select the divide datapath.
  assign op_div_s    = (op_q == OP_DIV) || (op_q == OP_MOD);
  assign start_div_s = (bus.op == OP_DIV) || (bus.op == OP_MOD);

  // Divide trial value: remainder shifted left with the next dividend bit; the bit
  // shifted out of R acts as the 33rd remainder bit.
  assign trial_s = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign shout_s = r_q[WIDTH-1];

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // Drive the shared adder for the current iteration and form the next R/Q.
  always_comb begin
    bus.add_a = {WIDTH{1'b0}};
    bus.add_b = {WIDTH{1'b0}};
    bus.add_s = 1'b0;
    r_d       = r_q;
    q_d       = q_q;
    if (state_q == S_RUN) begin
      if (op_div_s) begin
        bus.add_a = trial_s;
        bus.add_b = m_q;
        bus.add_s = 1'b1;
        if (shout_s || bus.add_cout) begin
          r_d = bus.add_sum;
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = trial_s;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        bus.add_a = r_q;
        bus.add_b = q_q[0] ? m_q : {WIDTH{1'b0}};
        bus.add_s = 1'b0;
        // {cout, sum, Q} shifted right by one; low half lands in Q.
        r_d = {bus.add_cout, bus.add_sum[WIDTH-1:1]};
        q_d = {bus.add_sum[0], q_q[WIDTH-1:1]};
      end
    end else begin
      r_d = r_q;
      q_d = q_q;
    end
  end

  // Control FSM plus operand/result registers; reset drops any op in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      op_q     <= 2'b00;
      m_q      <= {WIDTH{1'b0}};
      q_q      <= {WIDTH{1'b0}};
      r_q      <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q    <= bus.op;
            m_q     <= start_div_s ? bus.opb : bus.opa;
            q_q     <= start_div_s ? bus.opa : bus.opb;
            r_q     <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_q <= (op_q == OP_MOD) ? r_d : q_d;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
